// File: rtl/bus_sequencer.sv
// bus_sequencer: microcode T-state sequencer and bus arbiter for the 8-bit CPU.
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   opcode                IR[7:4], valid from T2 onward
//   flag_c, flag_z        registered carry / zero flags
//   dbg_req/mar/we        external loader bus request and its MAR-load / RAM-write strobes
//   bus_oe_n              {DOn,AOn,BOn,IOn,COn,EOn,ROn,NOn}, at most one bit low
//   *_ld, ram_we, pc_inc  active-high register strobes
//   alu_sub               ALU subtract select
//   dbg_gnt, halted       loader owns bus / CPU halted
//   step                  current T-state 0..4
module bus_sequencer #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7-ADDR_W:0] opcode,
    input  logic              flag_c,
    input  logic              flag_z,
    input  logic              dbg_req,
    input  logic              dbg_mar,
    input  logic              dbg_we,
    output logic [7:0]        bus_oe_n,
    output logic              mar_ld,
    output logic              ir_ld,
    output logic              a_ld,
    output logic              b_ld,
    output logic              ram_we,
    output logic              pc_ld,
    output logic              pc_inc,
    output logic              out_ld,
    output logic              flags_ld,
    output logic              alu_sub,
    output logic              dbg_gnt,
    output logic              halted,
    output logic [2:0]        step
);
    typedef enum logic [1:0] {RUN, DEBUG, HALT} state_t;
    localparam logic [2:0] SRC_D = 3'd7, SRC_A = 3'd6, SRC_I = 3'd4, SRC_C = 3'd3,
                           SRC_E = 3'd2, SRC_R = 3'd1;
    state_t     state, state_nx;
    logic [2:0] step_nx, last, src;
    logic       from_halt, from_halt_nx, src_en;
    // Final T-state of the current opcode.
    assign last = (opcode == 4'd1 || opcode == 4'd4) ? 3'd3 :
                  (opcode == 4'd2 || opcode == 4'd3) ? 3'd4 : 3'd2;
    // A single source index drives the enables, so two bits can never be low together.
    assign bus_oe_n = src_en ? ~(8'd1 << src) : 8'hFF;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            step      <= 3'd0;
            from_halt <= 1'b0;
        end else begin
            state     <= state_nx;
            step      <= step_nx;
            from_halt <= from_halt_nx;
        end
    end
    always_comb begin
        state_nx     = state;
        step_nx      = step;
        from_halt_nx = from_halt;
        case (state)
            RUN: begin
                if (step == 3'd0 && dbg_req) begin
                    state_nx     = DEBUG;
                    from_halt_nx = 1'b0;
                end else if (step == 3'd2 && opcode == 4'hF) begin
                    state_nx = HALT;
                    step_nx  = 3'd0;
                end else begin
                    step_nx = (step >= last) ? 3'd0 : step + 3'd1;
                end
            end
            DEBUG: begin
                step_nx = 3'd0;
                if (!dbg_req) state_nx = from_halt ? HALT : RUN;
            end
            HALT: begin
                step_nx = 3'd0;
                if (dbg_req) begin
                    state_nx     = DEBUG;
                    from_halt_nx = 1'b1;
                end
            end
            default: begin
                state_nx = RUN;
                step_nx  = 3'd0;
            end
        endcase
    end
    // Outputs are gated by rst_n so the bus is released the instant reset asserts.
    always_comb begin
        src_en   = 1'b0;
        src      = 3'd0;
        mar_ld   = 1'b0;
        ir_ld    = 1'b0;
        a_ld     = 1'b0;
        b_ld     = 1'b0;
        ram_we   = 1'b0;
        pc_ld    = 1'b0;
        pc_inc   = 1'b0;
        out_ld   = 1'b0;
        flags_ld = 1'b0;
        alu_sub  = 1'b0;
        dbg_gnt  = 1'b0;
        halted   = 1'b0;
        if (rst_n) begin
            case (state)
                RUN: begin
                    case (step)
                        3'd0: begin
                            src_en = 1'b1;
                            src    = SRC_C;
                            mar_ld = 1'b1;
                        end
                        3'd1: begin
                            src_en = 1'b1;
                            src    = SRC_R;
                            ir_ld  = 1'b1;
                            pc_inc = 1'b1;
                        end
                        3'd2: begin
                            src = SRC_I;
                            case (opcode)
                                4'd1, 4'd2, 4'd3, 4'd4: begin
                                    src_en = 1'b1;
                                    mar_ld = 1'b1;
                                end
                                4'd5: begin
                                    src_en = 1'b1;
                                    a_ld   = 1'b1;
                                end
                                4'd6: begin
                                    src_en = 1'b1;
                                    pc_ld  = 1'b1;
                                end
                                4'd7: begin
                                    src_en = flag_c;
                                    pc_ld  = flag_c;
                                end
                                4'd8: begin
                                    src_en = flag_z;
                                    pc_ld  = flag_z;
                                end
                                4'd14: begin
                                    src_en = 1'b1;
                                    src    = SRC_A;
                                    out_ld = 1'b1;
                                end
                                default: ;
                            endcase
                        end
                        3'd3: begin
                            case (opcode)
                                4'd1: begin
                                    src_en = 1'b1;
                                    src    = SRC_R;
                                    a_ld   = 1'b1;
                                end
                                4'd2, 4'd3: begin
                                    src_en  = 1'b1;
                                    src     = SRC_R;
                                    b_ld    = 1'b1;
                                    alu_sub = (opcode == 4'd3);
                                end
                                4'd4: begin
                                    src_en = 1'b1;
                                    src    = SRC_A;
                                    ram_we = 1'b1;
                                end
                                default: ;
                            endcase
                        end
                        3'd4: begin
                            if (opcode == 4'd2 || opcode == 4'd3) begin
                                src_en   = 1'b1;
                                src      = SRC_E;
                                a_ld     = 1'b1;
                                flags_ld = 1'b1;
                                alu_sub  = (opcode == 4'd3);
                            end
                        end
                        default: ;
                    endcase
                end
                DEBUG: begin
                    src_en  = 1'b1;
                    src     = SRC_D;
                    mar_ld  = dbg_mar;
                    ram_we  = dbg_we;
                    dbg_gnt = 1'b1;
                end
                HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_sequencer.sv
// tb_bus_sequencer: scoreboard bench driving instruction transactions against a table-level model.
module tb_bus_sequencer;
    typedef struct packed {
        logic [7:0] oe;
        logic mar, ir, a, b, we, pcl, pci, outl, fl, sub, gnt, hlt;
        logic [2:0] st;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst_n, flag_c, flag_z, dbg_req, dbg_mar, dbg_we;
    logic [3:0] opcode;
    logic [7:0] bus_oe_n;
    logic       mar_ld, ir_ld, a_ld, b_ld, ram_we, pc_ld, pc_inc, out_ld, flags_ld;
    logic       alu_sub, dbg_gnt, halted;
    logic [2:0] step;
    exp_t       sbq[$];
    int         n_pass = 0, n_total = 0;
    logic       pend = 1'b0;
    bus_sequencer dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
        .dbg_req(dbg_req), .dbg_mar(dbg_mar), .dbg_we(dbg_we), .bus_oe_n(bus_oe_n),
        .mar_ld(mar_ld), .ir_ld(ir_ld), .a_ld(a_ld), .b_ld(b_ld), .ram_we(ram_we),
        .pc_ld(pc_ld), .pc_inc(pc_inc), .out_ld(out_ld), .flags_ld(flags_ld),
        .alu_sub(alu_sub), .dbg_gnt(dbg_gnt), .halted(halted), .step(step)
    );
    always #5 clk = ~clk;
    function automatic int op_len(input logic [3:0] op);
        return (op == 4'd1 || op == 4'd4) ? 4 : (op == 4'd2 || op == 4'd3) ? 5 : 3;
    endfunction
    // Expected outputs for T-state k of an instruction, straight from the microcode table.
    function automatic exp_t run_exp(input logic [3:0] op, input int k, input logic c, input logic z);
        exp_t e;
        e = '0;
        e.oe = 8'hFF;
        e.st = 3'(k);
        if (k == 0) begin
            e.oe = 8'hF7; e.mar = 1'b1;
        end else if (k == 1) begin
            e.oe = 8'hFD; e.ir = 1'b1; e.pci = 1'b1;
        end else if (k == 2) begin
            if (op inside {4'd1, 4'd2, 4'd3, 4'd4}) begin e.oe = 8'hEF; e.mar = 1'b1; end
            else if (op == 4'd5) begin e.oe = 8'hEF; e.a = 1'b1; end
            else if (op == 4'd6 || (op == 4'd7 && c) || (op == 4'd8 && z)) begin e.oe = 8'hEF; e.pcl = 1'b1; end
            else if (op == 4'hE) begin e.oe = 8'hBF; e.outl = 1'b1; end
        end else if (k == 3) begin
            if (op == 4'd1) begin e.oe = 8'hFD; e.a = 1'b1; end
            else if (op == 4'd2 || op == 4'd3) begin e.oe = 8'hFD; e.b = 1'b1; e.sub = (op == 4'd3); end
            else if (op == 4'd4) begin e.oe = 8'hBF; e.we = 1'b1; end
        end else begin
            e.oe = 8'hFB; e.a = 1'b1; e.fl = 1'b1; e.sub = (op == 4'd3);
        end
        return e;
    endfunction
    function automatic exp_t idle_exp(input logic h);
        exp_t e;
        e = '0;
        e.oe = 8'hFF;
        e.hlt = h;
        return e;
    endfunction
    function automatic exp_t dbg_exp(input logic m, input logic w);
        exp_t e;
        e = '0;
        e.oe = 8'h7F; e.mar = m; e.we = w; e.gnt = 1'b1;
        return e;
    endfunction
    task automatic cyc(input exp_t e);
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask
    task automatic rnd_dbg_lines();
        dbg_mar = 1'($urandom_range(1));
        dbg_we  = 1'($urandom_range(1));
    endtask
    // One instruction; a pending request is granted at its T0, and a request raised from
    // step req_from onward stays pending until the next T0. rst_at aborts with reset.
    task automatic instr(input logic [3:0] op, input logic c, input logic z,
                         input int req_from, input int dbg_n, input int rst_at);
        int len;
        len = op_len(op);
        opcode = op; flag_c = c; flag_z = z;
        if (req_from == 0) pend = 1'b1;
        for (int k = 0; k < len; k++) begin
            rnd_dbg_lines();
            if (k == rst_at) begin
                rst_n = 1'b0;
                cyc(idle_exp(1'b0));
                cyc(idle_exp(1'b0));
                rst_n = 1'b1; dbg_req = 1'b0; pend = 1'b0;
                return;
            end
            if (k == 0) begin
                dbg_req = pend;
                if (pend) begin
                    cyc(run_exp(op, 0, c, z));
                    for (int n = 0; n <= dbg_n; n++) begin
                        rnd_dbg_lines();
                        dbg_req = (n < dbg_n);
                        cyc(dbg_exp(dbg_mar, dbg_we));
                    end
                    pend = 1'b0;
                    rnd_dbg_lines();
                end
            end else begin
                dbg_req = (req_from >= 0 && k >= req_from);
            end
            cyc(run_exp(op, k, c, z));
        end
        pend = (req_from >= 0);
    endtask
    always @(negedge clk) begin
        exp_t e, act;
        n_total++;
        if ($countones(~bus_oe_n) <= 1) n_pass++;
        else $display("FAIL oe_onehot t=%0t: bus_oe_n=%h required at most one low bit", $time, bus_oe_n);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            act = {bus_oe_n, mar_ld, ir_ld, a_ld, b_ld, ram_we, pc_ld, pc_inc, out_ld,
                   flags_ld, alu_sub, dbg_gnt, halted, step};
            n_total++;
            if (act === e) n_pass++;
            else $display("FAIL outputs t=%0t: got oe=%h str=%b gnt=%b hlt=%b st=%0d, want oe=%h str=%b gnt=%b hlt=%b st=%0d",
                          $time, act.oe, act[14:5], act.gnt, act.hlt, act.st,
                          e.oe, e[14:5], e.gnt, e.hlt, e.st);
        end
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [3:0] op;
        int rf;
        rst_n = 1'b0; opcode = 4'd0; flag_c = 1'b0; flag_z = 1'b0;
        dbg_req = 1'b0; dbg_mar = 1'b0; dbg_we = 1'b0;
        @(posedge clk);
        #1;
        cyc(idle_exp(1'b0));
        cyc(idle_exp(1'b0));
        rst_n = 1'b1;
        instr(4'd2, 1'b0, 1'b0, -1, 0, 3);
        instr(4'd1, 1'b0, 1'b0, -1, 0, -1);
        instr(4'd3, 1'b1, 1'b0, -1, 0, -1);
        instr(4'd7, 1'b1, 1'b0, -1, 0, -1);
        instr(4'd7, 1'b0, 1'b1, -1, 0, -1);
        instr(4'd8, 1'b0, 1'b1, -1, 0, -1);
        instr(4'd8, 1'b1, 1'b0, -1, 0, -1);
        instr(4'd4, 1'b0, 1'b0, -1, 0, -1);
        instr(4'd2, 1'b0, 1'b0, 2, 0, -1);
        instr(4'd5, 1'b0, 1'b0, -1, 3, -1);
        instr(4'hE, 1'b0, 1'b0, 0, 1, -1);
        instr(4'd9, 1'b1, 1'b1, -1, 0, -1);
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(14));
            rf = ($urandom_range(3) == 0) ? int'($urandom_range(op_len(op) - 1)) : -1;
            instr(op, 1'($urandom_range(1)), 1'($urandom_range(1)), rf,
                  int'($urandom_range(3)), -1);
        end
        instr(4'd0, 1'b0, 1'b0, -1, 2, -1);
        instr(4'hF, 1'b0, 1'b0, -1, 0, -1);
        dbg_req = 1'b0;
        cyc(idle_exp(1'b1));
        cyc(idle_exp(1'b1));
        dbg_req = 1'b1;
        cyc(idle_exp(1'b1));
        for (int n = 0; n < 3; n++) begin
            rnd_dbg_lines();
            dbg_req = (n < 2);
            cyc(dbg_exp(dbg_mar, dbg_we));
        end
        for (int n = 0; n < 3; n++) begin
            opcode = 4'($urandom_range(15));
            cyc(idle_exp(1'b1));
        end
        rst_n = 1'b0;
        cyc(idle_exp(1'b0));
        rst_n = 1'b1;
        instr(4'd1, 1'b0, 1'b0, -1, 0, -1);
        n_total++;
        if (sbq.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, required 0", sbq.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/bus_sequencer.md
Name: bus_sequencer

Overview:
- Microcode control sequencer for the 8-bit CPU.
- Steps through fetch/execute T-states and drives the active-low bus output enables for the shared 8-bit bus mux, plus the register load strobes.
- Arbitrates the bus between the CPU and an external debug/program loader, which owns the bus through the DEBUG source.

Parameters:
- ADDR_W, 4, width of operand field in IR[3:0] (informational; operand nibble is driven by IR source, not this block)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- opcode  input  4  IR[7:4], valid from T2 onward
- flag_c  input  1  registered carry flag
- flag_z  input  1  registered zero flag
- dbg_req  input  1  loader requests bus
- dbg_mar  input  1  loader: load MAR from bus (honoured only while granted)
- dbg_we  input  1  loader: write RAM from bus (honoured only while granted)
- bus_oe_n  output  8  {DOn,AOn,BOn,IOn,COn,EOn,ROn,NOn}; at most one bit low
- mar_ld, ir_ld, a_ld, b_ld, ram_we, pc_ld, pc_inc, out_ld, flags_ld  output  1 each  active-high strobes
- alu_sub  output  1  ALU subtract select
- dbg_gnt  output  1  loader owns bus
- halted  output  1  CPU halted
- step  output  3  current T-state 0..4

Behaviour:
- States: RUN (with step 0..4), DEBUG, HALT. All state is registered. Outputs decode combinationally from state, step, opcode and flags.
- Reset:
  - Asynchronous and active-low; may be asserted mid-instruction.
  - Forces RUN, step=0, dbg_gnt=0, halted=0.
  - While rst_n=0: bus_oe_n=8'hFF and all strobes 0.
- RUN decode. Any strobe not listed is 0; bus_oe_n=FF where no source is listed.
  - T0: COn low, mar_ld.
  - T1: ROn low, ir_ld, pc_inc.
  - T2 onward by opcode:
    - 0 NOP: T2 idle. Length 3.
    - 1 LDA: T2 IOn, mar_ld. T3 ROn, a_ld. Length 4.
    - 2 ADD: T2 IOn, mar_ld. T3 ROn, b_ld. T4 EOn, a_ld, flags_ld. Length 5.
    - 3 SUB: as ADD, with alu_sub=1 in T3 and T4.
    - 4 STA: T2 IOn, mar_ld. T3 AOn, ram_we. Length 4.
    - 5 LDI: T2 IOn, a_ld. Length 3.
    - 6 JMP: T2 IOn, pc_ld. Length 3.
    - 7 JC: T2 IOn+pc_ld if flag_c, else idle. Length 3.
    - 8 JZ: as JC using flag_z.
    - E OUT: T2 AOn, out_ld. Length 3.
    - F HLT: T2 idle, next state HALT.
    - 9–D: undefined, treated as NOP.
- Step advance:
  - Each clock step increments.
  - At the last step of the opcode, step returns to 0 on the next edge. Step never exceeds 4.
- Bus arbitration:
  - dbg_req is sampled only on edges where state=RUN and step=0, or state=HALT.
  - If dbg_req=1 on such an edge, the next state is DEBUG. The T0 strobes of that cycle still apply.
  - In DEBUG:
    - dbg_gnt=1, bus_oe_n=8'h7F (DOn low).
    - mar_ld=dbg_mar, ram_we=dbg_we. All other strobes 0.
    - Step is held at 0.
  - Exit: dbg_req=0 at an edge in DEBUG returns to the originating state (RUN step 0, or HALT). Remember the origin in a 1-bit register.
  - dbg_req is ignored mid-instruction. Grant latency from a T0 request is 1 clock; worst case is instruction length + 1.
- HALT:
  - halted=1, bus_oe_n=FF, all strobes 0, step=0.
  - Exited only by reset. Debug grants are still served.
- Invariant: bus_oe_n never has two bits low in any state, including during reset and during DEBUG.

Test Plan:
- Reset mid-ADD at T3 -> bus_oe_n=FF and strobes 0 immediately (async). After release: step=0, T0 shows bus_oe_n=F7 (COn low) and mar_ld=1.
- LDA opcode=1 -> cycle-by-cycle bus_oe_n: F7, FD, EF, FD, then F7 at the next T0. Strobes: mar_ld / ir_ld+pc_inc / mar_ld / a_ld. Instruction is 4 cycles.
- SUB opcode=3 -> T4 shows bus_oe_n=FB (EOn low), a_ld=1, flags_ld=1, alu_sub=1. Next cycle is step 0.
- JC opcode=7: with flag_c=1, T2 shows bus_oe_n=EF and pc_ld=1. With flag_c=0, T2 shows bus_oe_n=FF and pc_ld=0.
- dbg_req raised at T2 of ADD -> no grant until after T4. At T0 of the following instruction, the next cycle shows dbg_gnt=1, bus_oe_n=7F, and ram_we following dbg_we. Dropping dbg_req returns to RUN step 0.
- HLT opcode=F -> halted=1 from T2+1 onward, step stays 0. A debug request is granted with 1-cycle latency. After it is released, halted remains 1 until rst_n=0.
